// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into an instruction word, buffered out.
// Optional: define INSTR_ENCODER_RANGE_CHECK_EN to flag out-of-range/misaligned immediates.
module instr_encoder #(
    parameter int FIFO_DEPTH = 2,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [1:0]         out_err,
    output logic [COUNT_W-1:0] enc_count
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    logic is_r;
    logic is_i;
    logic is_s;
    logic is_b;
    logic is_u;
    logic is_j;
    logic known;

    assign is_r  = (in_opcode == 7'b0110011);
    assign is_i  = (in_opcode == 7'b0010011) ||
                   (in_opcode == 7'b0000011) ||
                   (in_opcode == 7'b1100111);
    assign is_s  = (in_opcode == 7'b0100011);
    assign is_b  = (in_opcode == 7'b1100011);
    assign is_u  = (in_opcode == 7'b0110111) ||
                   (in_opcode == 7'b0010111);
    assign is_j  = (in_opcode == 7'b1101111);
    assign known = is_r | is_i | is_s | is_b | is_u | is_j;

    logic [31:0] enc_instr;
    logic [1:0]  chk_err;
    logic [1:0]  enc_err;

    // Scatter the fields into the format selected by the opcode
    always_comb begin
        enc_instr = '0;
        unique case (1'b1)
            is_r: enc_instr = {in_funct7, in_rs2, in_rs1,
                               in_funct3, in_rd, in_opcode};
            is_i: enc_instr = {in_imm[11:0], in_rs1,
                               in_funct3, in_rd, in_opcode};
            is_s: enc_instr = {in_imm[11:5], in_rs2, in_rs1,
                               in_funct3, in_imm[4:0], in_opcode};
            is_b: enc_instr = {in_imm[12], in_imm[10:5], in_rs2,
                               in_rs1, in_funct3, in_imm[4:1],
                               in_imm[11], in_opcode};
            is_u: enc_instr = {in_imm[31:12], in_rd, in_opcode};
            is_j: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11],
                               in_imm[19:12], in_rd, in_opcode};
            default: enc_instr = '0;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic signed [31:0] simm;
    logic               i_oor;
    logic               b_oor;
    logic               j_oor;

    assign simm  = $signed(in_imm);
    assign i_oor = (simm < -32'sd2048) || (simm > 32'sd2047);
    assign b_oor = (simm < -32'sd4096) || (simm > 32'sd4094);
    assign j_oor = (simm < -32'sd1048576) || (simm > 32'sd1048574);

    // Immediate legality per format; misalignment outranks range
    always_comb begin
        chk_err = 2'd0;
        unique case (1'b1)
            is_i, is_s: begin
                if (i_oor) chk_err = 2'd1;
            end
            is_b: begin
                if (in_imm[0])  chk_err = 2'd2;
                else if (b_oor) chk_err = 2'd1;
            end
            is_j: begin
                if (in_imm[0])  chk_err = 2'd2;
                else if (j_oor) chk_err = 2'd1;
            end
            is_u: begin
                if (in_imm[11:0] != 12'd0) chk_err = 2'd2;
            end
            default: chk_err = 2'd0;
        endcase
    end
`else
    logic unused_imm;
    assign unused_imm = in_imm[0];
    assign chk_err    = 2'd0;
`endif

    assign enc_err = known ? chk_err : 2'd3;

    logic [31:0]      mem_instr [FIFO_DEPTH];
    logic [1:0]       mem_err   [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [OCC_W-1:0] occ;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full      = (occ == OCC_FULL);
    assign empty     = (occ == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = !empty && out_ready;
    assign out_instr = empty ? 32'd0 : mem_instr[rptr];
    assign out_err   = empty ? 2'd0 : mem_err[rptr];

    // Storage is only observable through occupancy, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wptr] <= enc_instr;
            mem_err[wptr]   <= enc_err;
        end
    end

    // Pointers, occupancy and the pop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            occ       <= '0;
            enc_count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop) begin
                rptr      <= rptr + PTR_W'(1);
                enc_count <= enc_count + COUNT_W'(1);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: random + directed stimulus against a format-level
// reference encoder and a queue model of the output buffer.
module tb_instr_encoder;
    localparam int DEPTH = 2;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [1:0]    out_err;
    logic [CW-1:0] enc_count;

    instr_encoder #(.FIFO_DEPTH(DEPTH), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [1:0]  err;
    } ent_t;

    typedef enum int {F_R, F_I, F_S, F_B, F_U, F_J, F_X} fmt_t;

    ent_t          mq[$];
    logic [CW-1:0] mcount;
    int            vectors     = 0;
    int            miscompares = 0;
    bit            chk_on      = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic ent_t ref_enc(
        input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] f3, input logic [6:0] f7,
        input logic [31:0] imm);
        ent_t e;
        fmt_t f;
        int   v;
        e.instr = 32'd0;
        e.err   = 2'd0;
        v = $signed(imm);
        case (op)
            7'h33:               f = F_R;
            7'h13, 7'h03, 7'h67: f = F_I;
            7'h23:               f = F_S;
            7'h63:               f = F_B;
            7'h37, 7'h17:        f = F_U;
            7'h6F:               f = F_J;
            default:             f = F_X;
        endcase
        if (f == F_X) begin
            e.err = 2'd3;
            return e;
        end
        e.instr[6:0] = op;
        case (f)
            F_R: begin
                e.instr[11:7] = rd; e.instr[14:12] = f3;
                e.instr[19:15] = rs1; e.instr[24:20] = rs2;
                e.instr[31:25] = f7;
            end
            F_I: begin
                e.instr[11:7] = rd; e.instr[14:12] = f3;
                e.instr[19:15] = rs1; e.instr[31:20] = imm[11:0];
            end
            F_S: begin
                e.instr[11:7] = imm[4:0]; e.instr[14:12] = f3;
                e.instr[19:15] = rs1; e.instr[24:20] = rs2;
                e.instr[31:25] = imm[11:5];
            end
            F_B: begin
                e.instr[7] = imm[11]; e.instr[11:8] = imm[4:1];
                e.instr[14:12] = f3; e.instr[19:15] = rs1;
                e.instr[24:20] = rs2; e.instr[30:25] = imm[10:5];
                e.instr[31] = imm[12];
            end
            F_U: begin
                e.instr[11:7] = rd; e.instr[31:12] = imm[31:12];
            end
            default: begin
                e.instr[11:7] = rd; e.instr[19:12] = imm[19:12];
                e.instr[20] = imm[11]; e.instr[30:21] = imm[10:1];
                e.instr[31] = imm[20];
            end
        endcase
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        case (f)
            F_I, F_S: if (v < -2048 || v > 2047) e.err = 2'd1;
            F_B: begin
                if (imm[0]) e.err = 2'd2;
                else if (v < -4096 || v > 4094) e.err = 2'd1;
            end
            F_J: begin
                if (imm[0]) e.err = 2'd2;
                else if (v < -(1 << 20) || v > (1 << 20) - 2) e.err = 2'd1;
            end
            F_U: if (imm[11:0] != 12'd0) e.err = 2'd2;
            default: e.err = 2'd0;
        endcase
`endif
        return e;
    endfunction

    // Buffer model: one pop and/or one push per accepted clock edge
    ent_t nw;
    bit   do_push;
    bit   do_pop;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mcount <= '0;
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop  = (mq.size() != 0) && out_ready;
            nw = ref_enc(in_opcode, in_rd, in_rs1, in_rs2,
                         in_funct3, in_funct7, in_imm);
            if (do_pop) begin
                void'(mq.pop_front());
                mcount <= mcount + 1'b1;
            end
            if (do_push) mq.push_back(nw);
        end
    end

    // Compare DUT against model every cycle
    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < DEPTH});
            chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
            chk("enc_count", {16'd0, enc_count}, {16'd0, mcount});
            if (mq.size() != 0 && out_valid) begin
                chk("out_instr", out_instr, mq[0].instr);
                chk("out_err", {30'd0, out_err}, {30'd0, mq[0].err});
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [31:0] imm);
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = 7'd0; in_imm = imm;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (!out_valid) break;
            cyc();
        end
        out_ready = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm, input logic [31:0] ei,
                       input logic [1:0] ee);
        ent_t m;
        m = ref_enc(op, rd, rs1, rs2, f3, 7'd0, imm);
        chk({nm, "_model"}, m.instr, ei);
        chk({nm, "_model_err"}, {30'd0, m.err}, {30'd0, ee});
        drain();
        chk({nm, "_pre"}, {31'd0, out_valid}, 32'd0);
        set_in(op, rd, rs1, rs2, f3, imm);
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk({nm, "_lat"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_instr"}, out_instr, ei);
        chk({nm, "_err"}, {30'd0, out_err}, {30'd0, ee});
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    logic [6:0]    ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                                7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    logic [31:0]   got [3];
    logic [31:0]   ws  [3];
    logic [CW-1:0] cnt0;
    int            ngot;
    bit            acc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        cyc(); cyc();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {30'd0, out_err}, 32'd0);
        chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
        rst = 1'b0;
        chk_on = 1'b1;

        lit("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF00093, 2'd0);
        lit("sw", 7'h23, 5'd0, 5'd3, 5'd2, 3'd2, 32'd4, 32'h0021A223, 2'd0);
        lit("beq", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd8, 32'h00000463, 2'd0);
        lit("jal", 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800, 32'h001000EF, 2'd0);
        lit("lui", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 2'd0);
        lit("unk", 7'h7F, 5'd9, 5'd4, 5'd7, 3'd5, 32'h55, 32'h0, 2'd3);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        lit("b_mis", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 32'h00000163, 2'd2);
        lit("i_oor", 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h80000013, 2'd1);
`endif

        // backpressure: three words, buffer holds two
        drain();
        ws[0] = 32'hFFF00093; ws[1] = 32'hFFF00113; ws[2] = 32'hFFF00193;
        in_valid = 1'b1;
        set_in(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF); cyc();
        set_in(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF); cyc();
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        set_in(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF); cyc();
        chk("bp_hold", {31'd0, in_ready}, 32'd0);
        cnt0 = enc_count;
        out_ready = 1'b1;
        ngot = 0;
        for (int k = 0; k < 12 && ngot < 3; k++) begin
            if (out_valid) begin
                got[ngot] = out_instr;
                ngot++;
            end
            acc = in_valid && in_ready;
            cyc();
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        chk("bp_words", ngot, 3);
        for (int k = 0; k < 3; k++) chk($sformatf("bp_order%0d", k), got[k], ws[k]);
        chk("bp_count", {16'd0, enc_count - cnt0}, 32'd3);

        // asynchronous reset with two entries queued
        set_in(7'h33, 5'd4, 5'd5, 5'd6, 3'd1, 32'd0);
        in_valid = 1'b1; cyc();
        set_in(7'h6F, 5'd2, 5'd0, 5'd0, 3'd0, 32'h100); cyc();
        in_valid = 1'b0;
        chk("mid_two", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_count", {16'd0, enc_count}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        #1 rst = 1'b0;
        lit("post_rst", 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 2'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_opcode = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) in_opcode = 7'($urandom);
            in_rd = 5'($urandom); in_rs1 = 5'($urandom);
            in_rs2 = 5'($urandom); in_funct3 = 3'($urandom);
            in_funct7 = 7'($urandom);
            case ($urandom_range(0, 2))
                0: in_imm = 32'($signed($urandom_range(0, 10000)) - 5000);
                1: in_imm = $urandom;
                default: in_imm = {20'($urandom), 12'd0};
            endcase
            if ($urandom_range(0, 399) == 0) begin
                #1 rst = 1'b1;
                #1;
                chk("rnd_rst_valid", {31'd0, out_valid}, 32'd0);
                chk("rnd_rst_count", {16'd0, enc_count}, 32'd0);
                #1 rst = 1'b0;
            end
            cyc();
        end
        in_valid = 1'b0;
        drain();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
